// File: rtl/prng_source_if.sv
// ============================================================================
// Module   : prng_source_if
// Purpose  : Random-word handshake and status bundle of prng_source.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface prng_source_if #(
    parameter int OUT_W = 9,
    parameter int LVL_W = 3
);
    logic             rand_valid;
    logic             rand_ready;
    logic [OUT_W-1:0] rand_data;
    logic [LVL_W-1:0] level;
    logic             busy;

    modport master (
        output rand_valid, rand_data, level, busy,
        input  rand_ready
    );

    modport slave (
        input  rand_valid, rand_data, level, busy,
        output rand_ready
    );
endinterface

`default_nettype wire

// File: rtl/prng_source.sv
// ============================================================================
// Module   : prng_source
// Purpose  : Seeded 32-bit Galois LFSR sampled into a small FWFT word FIFO.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prng_source #(
    parameter int                LFSR_W        = 32,
    parameter int                OUT_W         = 9,
    parameter int                FIFO_DEPTH    = 4,
    parameter int                WARMUP_CYCLES = 16,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED  = 32'hACE1_2468,
    parameter bit                UNIT_RANGE    = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en,
    input  wire logic              seed_load,
    input  wire logic [LFSR_W-1:0] seed,
    prng_source_if.master          rng
);
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_cnt_w = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [LFSR_W-1:0] c_poly     = 32'h8020_0003;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WARMUP_CYCLES - 1);
    localparam logic [c_lvl_w-1:0] c_depth    = c_lvl_w'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [LFSR_W-1:0]    r_lfsr;
    logic [LFSR_W-1:0]    w_lfsr_step;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [OUT_W-1:0]     r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_lvl_w-1:0]   r_level;
    logic [OUT_W-1:0]     w_word;
    logic                 w_pop;
    logic                 w_push;

    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_poly) : (r_lfsr >> 1);

    generate
        if (UNIT_RANGE) begin : g_unit_range
            assign w_word = {1'b0, r_lfsr[OUT_W-2:0]};
        end else begin : g_full_range
            assign w_word = r_lfsr[OUT_W-1:0];
        end
    endgenerate

    assign rng.rand_valid = (r_level != '0);
    assign rng.rand_data  = r_mem[r_rd_ptr];
    assign rng.level      = r_level;
    assign rng.busy       = (r_state == ST_WARMUP);

    assign w_pop  = rng.rand_valid & rng.rand_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = (r_state == ST_RUN) & en & ~seed_load & ((r_level < c_depth) | w_pop);

    always_comb begin
        w_state_next = r_state;
        if (seed_load) begin
            w_state_next = ST_WARMUP;
        end else if ((r_state == ST_WARMUP) && en && (r_cnt == c_cnt_last)) begin
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WARMUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= DEFAULT_SEED;
            r_cnt  <= '0;
        end else if (seed_load) begin
            r_lfsr <= (seed == '0) ? DEFAULT_SEED : seed;
            r_cnt  <= '0;
        end else if (en) begin
            r_lfsr <= w_lfsr_step;
            if (r_state == ST_WARMUP) begin
                r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (seed_load) begin
            // Flush only; storage contents are hidden behind rand_valid=0.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_prng_source.sv
// ============================================================================
// Module   : tb_prng_source
// Purpose  : Randomized self-checking bench for prng_source with a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prng_source;
    localparam int          W     = 1;
    localparam int          DEPTH = 4;
    localparam int          LVL_W = 3;
    localparam logic [31:0] DEF   = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        seed_load = 1'b0;
    logic [31:0] seed = '0;
    logic        ready = 1'b0;

    always #5 clk = ~clk;

    prng_source_if #(.OUT_W(9), .LVL_W(LVL_W)) rng_if ();
    prng_source_if #(.OUT_W(9), .LVL_W(LVL_W)) raw_if ();

    assign rng_if.rand_ready = ready;
    assign raw_if.rand_ready = 1'b1;

    prng_source #(.WARMUP_CYCLES(W), .FIFO_DEPTH(DEPTH), .UNIT_RANGE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed), .rng(rng_if)
    );

    prng_source #(.WARMUP_CYCLES(W), .FIFO_DEPTH(DEPTH), .UNIT_RANGE(1'b0)) u_dut_raw (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed), .rng(raw_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: LFSR value, warm-up steps still owed, buffered words.
    int unsigned m_lfsr = DEF;
    int          m_warm = W;
    logic [8:0]  m_q[$];
    logic [8:0]  dut_log[$];
    logic [8:0]  raw_log[$];
    logic [8:0]  ref_stream[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned lfsr_next(input int unsigned s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic model_update();
        bit pop;
        pop = (m_q.size() > 0) && ready;
        if (rst) begin
            m_lfsr = DEF;
            m_warm = W;
            m_q.delete();
        end else if (seed_load) begin
            m_lfsr = (seed == 0) ? DEF : seed;
            m_warm = W;
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (en) begin
                if (m_warm > 0) m_warm--;
                else if (m_q.size() < DEPTH) m_q.push_back({1'b0, m_lfsr[7:0]});
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
    endtask

    task automatic step_cycle();
        @(negedge clk);
        check_eq("valid", 32'(rng_if.rand_valid), 32'(m_q.size() > 0));
        check_eq("level", 32'(rng_if.level), 32'(m_q.size()));
        check_eq("busy", 32'(rng_if.busy), 32'(m_warm > 0));
        if (m_q.size() > 0) check_eq("data", 32'(rng_if.rand_data), 32'(m_q[0]));
        if (rng_if.rand_valid && ready && !rst) dut_log.push_back(rng_if.rand_data);
        if (raw_if.rand_valid && !rst) raw_log.push_back(raw_if.rand_data);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_words(input int n, input int bound);
        int k = 0;
        while (dut_log.size() < n && k < bound) begin
            step_cycle();
            k++;
        end
        if (dut_log.size() < n) check_eq("word_timeout", 32'(dut_log.size()), 32'(n));
    endtask

    initial begin
        int unsigned s;
        int          k;
        logic [2:0]  lvl_before;
        logic [8:0]  exp_head;
        logic [8:0]  exp_seq [3];

        repeat (2) @(posedge clk);
        #1;
        step_cycle();
        check_eq("rst_data", 32'(rng_if.rand_data), 32'h0);

        // Stream straight out of reset, remembered for the zero-seed check.
        rst = 1'b0;
        ready = 1'b1;
        dut_log.delete();
        run_until_words(8, 100);
        ref_stream = dut_log;

        repeat (200) begin
            ready = 1'($urandom_range(0, 1));
            step_cycle();
        end

        ready = 1'b1;
        seed = 32'h1;
        seed_load = 1'b1;
        step_cycle();
        seed_load = 1'b0;
        dut_log.delete();
        run_until_words(3, 20);
        exp_seq = '{9'h003, 9'h002, 9'h001};
        for (int i = 0; i < 3; i++)
            if (i < dut_log.size()) check_eq("seed1_seq", 32'(dut_log[i]), 32'(exp_seq[i]));

        seed = 32'h0;
        seed_load = 1'b1;
        step_cycle();
        seed_load = 1'b0;
        dut_log.delete();
        run_until_words(8, 100);
        for (int i = 0; i < 8; i++)
            if (i < dut_log.size()) check_eq("zero_seed", 32'(dut_log[i]), 32'(ref_stream[i]));

        repeat (10) step_cycle();
        ready = 1'b0;
        repeat (10) step_cycle();
        check_eq("bp_level", 32'(rng_if.level), 32'd4);
        check_eq("bp_valid", 32'(rng_if.rand_valid), 32'd1);
        ready = 1'b1;
        repeat (20) step_cycle();

        ready = 1'b0;
        repeat (2) step_cycle();
        lvl_before = rng_if.level;
        en = 1'b0;
        repeat (5) step_cycle();
        check_eq("frz_level", 32'(rng_if.level), 32'(lvl_before));
        ready = 1'b1;
        repeat (6) step_cycle();
        check_eq("frz_drain", 32'(rng_if.level), 32'd0);
        en = 1'b1;
        repeat (20) step_cycle();

        ready = 1'b0;
        k = 0;
        while (m_q.size() != 3 && k < 20) begin
            step_cycle();
            k++;
        end
        check_eq("rp_level3", 32'(rng_if.level), 32'd3);
        exp_head = m_q[0];
        dut_log.delete();
        seed = $urandom | 32'h1;
        seed_load = 1'b1;
        ready = 1'b1;
        step_cycle();
        seed_load = 1'b0;
        check_eq("rp_popped_n", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) check_eq("rp_popped", 32'(dut_log[$]), 32'(exp_head));
        check_eq("rp_level0", 32'(rng_if.level), 32'd0);
        check_eq("rp_busy", 32'(rng_if.busy), 32'd1);
        repeat (5) step_cycle();

        // Unmasked instance: compare 40 words against the plain LFSR walk.
        seed = 32'h100;
        seed_load = 1'b1;
        step_cycle();
        seed_load = 1'b0;
        raw_log.delete();
        k = 0;
        while (raw_log.size() < 40 && k < 60) begin
            step_cycle();
            k++;
        end
        check_eq("raw_count", 32'(raw_log.size()), 32'd40);
        if (raw_log.size() > 0) check_eq("raw_first", 32'(raw_log[0]), 32'h080);
        s = lfsr_next(32'h100);
        for (int i = 0; i < 40; i++) begin
            if (i < raw_log.size()) check_eq("raw_word", 32'(raw_log[i]), 32'(s[8:0]));
            s = lfsr_next(s);
        end

        for (int i = 0; i < 30000; i++) begin
            ready     = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 9) != 0);
            seed_load = ($urandom_range(0, 499) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            rst       = ($urandom_range(0, 2999) == 0);
            step_cycle();
            if (rng_if.rand_valid) check_eq("unit_bit8", 32'(rng_if.rand_data[8]), 32'd0);
        end
        rst = 1'b0;
        seed_load = 1'b0;
        en = 1'b1;
        step_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
